// File: rtl/muldiv_seq.sv
// Sequential signed multiply/divide unit: radix-2 shift-add MUL and restoring DIV into HI/LO.
// Define MULDIV_DIV_EN to build the divider; without it DIV decodes as an illegal instruction.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result,
  output logic             illegal,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start
  // MUL   | one multiplier bit per cycle, WIDTH cycles
  // DIV   | one quotient bit per cycle, WIDTH cycles
  // FIX   | apply signs and load HI/LO (also the divide-by-zero load)
  // DONE  | done pulse; a new start may be accepted here

  localparam logic [5:0] OP_RTYPE1 = 6'h00;
  localparam logic [5:0] OP_RTYPE2 = 6'h1C;
  localparam logic [5:0] FN_MUL    = 6'h02;
  localparam logic [5:0] FN_DIV    = 6'h1A;
  localparam logic [5:0] FN_MFHI   = 6'h10;
  localparam logic [5:0] FN_MFLO   = 6'h12;

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH % 2) != 0) begin : g_width_check
    $error("muldiv_seq: WIDTH must be even and within 8..64");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 illegal_q, illegal_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 op_mul;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_signed;

`ifdef MULDIV_DIV_EN
  logic                 is_div_q, is_div_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 dbz_q, dbz_d;
  logic                 op_div;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH+1:0]     div_diff;
  logic                 div_ok;
`endif

  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;
  assign op_mul = (opcode == OP_RTYPE2) && (funct == FN_MUL);

  // acc holds {partial product, remaining multiplier bits}; the sum carries into the shift
  assign mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign prod_signed = neg_lo_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  assign op_div    = (opcode == OP_RTYPE1) && (funct == FN_DIV);
  // acc holds {partial remainder, dividend bits shifting into quotient bits}
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  assign div_ok    = ~div_diff[WIDTH+1];
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    neg_lo_d  = neg_lo_q;
    illegal_d = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div_d  = is_div_q;
    neg_hi_d  = neg_hi_q;
    dbz_d     = dbz_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (op_mul) begin
            acc_d    = {{WIDTH{1'b0}}, b_mag};
            opnd_d   = a_mag;
            neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
            cnt_d    = CNT_INIT;
            state_d  = S_MUL;
`ifdef MULDIV_DIV_EN
            is_div_d = 1'b0;
            dbz_d    = 1'b0;
`endif
          end
`ifdef MULDIV_DIV_EN
          else if (op_div) begin
            is_div_d = 1'b1;
            neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
            neg_hi_d = a[WIDTH-1];
            opnd_d   = b_mag;
            cnt_d    = CNT_INIT;
            if (b == '0) begin
              // raw dividend kept for HI; no iteration
              acc_d   = {{WIDTH{1'b0}}, a};
              dbz_d   = 1'b1;
              state_d = S_FIX;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, a_mag};
              dbz_d   = 1'b0;
              state_d = S_DIV;
            end
          end
`endif
          else begin
            illegal_d = 1'b1;
          end
        end
      end

      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end

      S_DIV: begin
`ifdef MULDIV_DIV_EN
        acc_d = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ok};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
`else
        state_d = S_IDLE;
`endif
      end

      S_FIX: begin
        state_d = S_DONE;
`ifdef MULDIV_DIV_EN
        if (dbz_q) begin
          lo_d = '1;
          hi_d = acc_q[WIDTH-1:0];
        end else if (is_div_q) begin
          lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          hi_d = prod_signed[2*WIDTH-1:WIDTH];
          lo_d = prod_signed[WIDTH-1:0];
        end
`else
        hi_d = prod_signed[2*WIDTH-1:WIDTH];
        lo_d = prod_signed[WIDTH-1:0];
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_lo_q  <= 1'b0;
      illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      neg_lo_q  <= neg_lo_d;
      illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
      is_div_q  <= is_div_d;
      neg_hi_q  <= neg_hi_d;
      dbz_q     <= dbz_d;
`endif
    end
  end

  always_comb begin
    result = '0;
    if (opcode == OP_RTYPE1 && funct == FN_MFHI)      result = hi_q;
    else if (opcode == OP_RTYPE1 && funct == FN_MFLO) result = lo_q;
  end

  assign busy    = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done    = (state_q == S_DONE);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign illegal = illegal_q;

`ifdef MULDIV_DIV_EN
  assign div_by_zero = (state_q == S_DONE) && dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random MUL/DIV/illegal ops
// against a plain-arithmetic reference of HI/LO, latency and flags.
module tb_muldiv_seq;

  localparam int W = 32;
  localparam logic [5:0] OP_RTYPE1 = 6'h00;
  localparam logic [5:0] OP_RTYPE2 = 6'h1C;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] FN_MUL    = 6'h02;
  localparam logic [5:0] FN_DIV    = 6'h1A;
  localparam logic [5:0] FN_MFHI   = 6'h10;
  localparam logic [5:0] FN_MFLO   = 6'h12;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   opcode = '0;
  logic [5:0]   funct = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, illegal, div_by_zero;
  logic [W-1:0] hi, lo, result;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .funct(funct),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .result(result), .illegal(illegal), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Signed arithmetic reference for HI/LO
  function automatic void model(input bit is_div, input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    longint sa, sb, p, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (!is_div) begin
      p  = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (bv == '0) begin
      el = '1;
      eh = av;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      el = q[31:0];
      eh = r[31:0];
    end
  endfunction

  task automatic check_result();
    opcode = OP_RTYPE1; funct = FN_MFHI; #1;
    check("mfhi", result, mhi);
    funct = FN_MFLO; #1;
    check("mflo", result, mlo);
    funct = FN_MUL; #1;
    check("result_other", result, 0);
  endtask

  task automatic do_op(input logic [5:0] opc, input logic [5:0] fn,
                       input logic [W-1:0] av, input logic [W-1:0] bv);
    bit           is_mul, is_div, dz;
    int           lat, exp_lat;
    logic [W-1:0] eh, el;
    is_mul = (opc == OP_RTYPE2) && (fn == FN_MUL);
    is_div = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div = (opc == OP_RTYPE1) && (fn == FN_DIV);
`endif
    @(negedge clk);
    opcode = opc; funct = fn; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!is_mul && !is_div) begin
      check("illegal_pulse", illegal, 1);
      check("illegal_busy", busy, 0);
      check("illegal_done", done, 0);
      check("illegal_hi", hi, mhi);
      check("illegal_lo", lo, mlo);
      @(posedge clk); #1;
      check("illegal_clear", illegal, 0);
      check("illegal_nodone", done, 0);
    end else begin
      model(is_div, av, bv, eh, el);
      dz      = is_div && (bv == '0);
      exp_lat = dz ? 1 : W + 1;
      check("busy_after_start", busy, 1);
      check("hi_stable_busy", hi, mhi);
      check("lo_stable_busy", lo, mlo);
      lat = 0;
      while (!done && lat < 3 * W) begin
        @(posedge clk); #1;
        lat++;
      end
      check("latency", lat, exp_lat);
      check("hi", hi, eh);
      check("lo", lo, el);
      check("div_by_zero", div_by_zero, dz);
      check("busy_at_done", busy, 0);
      check("illegal_at_done", illegal, 0);
      mhi = eh;
      mlo = el;
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("dbz_one_cycle", div_by_zero, 0);
    end
    check_result();
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return MIN_NEG;
      2:       return '1;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int           done_cnt;
    logic [W-1:0] ra, rb;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    do_op(OP_RTYPE2, FN_MUL, 32'd7, -32'sd3);
    check("mul_7_m3_hi", mhi, 32'hFFFF_FFFF);
    check("mul_7_m3_lo", mlo, 32'hFFFF_FFEB);
    do_op(OP_RTYPE1, FN_DIV, -32'sd17, 32'd5);
    do_op(OP_RTYPE1, FN_DIV, 32'd100, 32'd0);
    do_op(OP_RTYPE1, FN_DIV, MIN_NEG, '1);
    do_op(OP_RTYPE2, FN_MUL, MIN_NEG, MIN_NEG);
    do_op(OP_ADDI, FN_MUL, 32'd1, 32'd2);
    do_op(OP_RTYPE1, FN_DIV, 32'd9, 32'd3);
    do_op(OP_RTYPE1, FN_MFLO, 32'd4, 32'd4);

    // start while busy is ignored, then reset aborts the multiply
    @(negedge clk);
    opcode = OP_RTYPE2; funct = FN_MUL; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 5) begin
        opcode = OP_RTYPE2; funct = FN_MUL; a = 32'd1234; b = 32'd99; start = 1'b1;
      end else begin
        start = 1'b0;
        opcode = OP_RTYPE1; funct = FN_MFLO;
      end
      @(posedge clk); #1;
      if (k == 5 || k == 6) check("busy_ignores_start", busy, 1);
    end
    start = 1'b0;
    opcode = OP_RTYPE1; funct = FN_MFLO; #1;
    check("mflo_while_busy", result, mlo);
    check("hi_while_busy", hi, mhi);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (2 * W) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_lo_after", lo, 0);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      ra = pick_operand();
      rb = pick_operand();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: do_op(OP_RTYPE2, FN_MUL, ra, rb);
        5, 6, 7, 8:    do_op(OP_RTYPE1, FN_DIV, ra, rb);
        default:       do_op(OP_ADDI, 6'($urandom_range(0, 63)), ra, rb);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/HI/LO width; legal values 8..64, even.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request strobe; sampled on a rising edge only while busy=0.
REQ-005 opcode  input  6  instruction opcode; encodings per Opcode.vh.
REQ-006 funct  input  6  instruction funct field; encodings per Opcode.vh.
REQ-007 a  input  WIDTH  operand rs (dividend/multiplicand), two's complement.
REQ-008 b  input  WIDTH  operand rt (divisor/multiplier), two's complement.
REQ-009 busy  output  1  high while a MUL/DIV is in flight.
REQ-010 done  output  1  one-cycle pulse when HI/LO hold a new result.
REQ-011 hi  output  WIDTH  HI register.
REQ-012 lo  output  WIDTH  LO register.
REQ-013 result  output  WIDTH  MFHI->hi, MFLO->lo, else 0; combinational from opcode/funct.
REQ-014 illegal  output  1  one-cycle pulse: start accepted with unsupported opcode/funct.
REQ-015 div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV with b=0.

Function
REQ-016 FSM states IDLE, MUL, DIV, FIX, DONE; busy=1 in MUL, DIV, FIX only.
REQ-017 Accepted start with opcode=RTYPE2 and funct=MUL -> latch |a|, |b|, result sign; go to MUL.
REQ-018 Accepted start with opcode=RTYPE1 and funct=DIV, b!=0 -> latch magnitudes and quotient/remainder signs; go to DIV.
REQ-019 MUL: radix-2 shift-add, one multiplier bit per cycle, WIDTH cycles, 2*WIDTH-bit product; then FIX.
REQ-020 DIV: restoring division, one quotient bit per cycle, WIDTH cycles; then FIX.
REQ-021 FIX: one cycle; apply signs (quotient negative iff signs differ; remainder takes dividend sign); load hi/lo; go to DONE.
REQ-022 MUL writes hi=product[2W-1:W], lo=product[W-1:0]; DIV writes lo=quotient, hi=remainder.
REQ-023 DONE: done=1 for exactly one cycle; busy=0; next state IDLE, or a new op if start accepted that cycle.
REQ-024 Latency: start edge to done high = WIDTH+2 cycles for MUL and DIV (b!=0).
REQ-025 DIV with b=0: skip iteration; on next edge load lo=all ones, hi=a; go to DONE; done and div_by_zero high together, 2 cycles after start.
REQ-026 DIV of most-negative by -1 yields lo=most-negative, hi=0 (wraps); no flag.
REQ-027 start while busy=1 is ignored: no state, operand or HI/LO change.
REQ-028 Accepted start with any other opcode/funct: illegal=1 on next cycle, state stays IDLE, HI/LO unchanged.
REQ-029 hi/lo change only in FIX or the b=0 path; stable otherwise, including while busy.
REQ-030 MFHI/MFLO read via result never stalls; during busy it returns the previous HI/LO.

Reset
REQ-031 rst_n=0 at a rising edge: state=IDLE; hi=lo=0; busy, done, illegal, div_by_zero=0; iteration counter and internal registers cleared.
REQ-032 Reset mid-operation aborts the op; no done pulse and no HI/LO update for the aborted op.
REQ-033 First start honoured on the first edge with rst_n=1.

Configuration
REQ-034 Macro MULDIV_DIV_EN defined: DIV supported per REQ-018..026.
REQ-035 MULDIV_DIV_EN undefined: no divider logic; DIV is unsupported per REQ-028; div_by_zero tied to 0.

Verification
REQ-036 WIDTH=32, MUL a=7, b=-3 -> done 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-037 DIV a=-17, b=5 -> done 34 cycles after start; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2); div_by_zero=0.
REQ-038 DIV a=100, b=0 -> done and div_by_zero 2 cycles after start; lo=0xFFFFFFFF, hi=100.
REQ-039 MUL in flight; second start at cycle 5; rst_n=0 at cycle 10 -> second start ignored; after reset hi=lo=0 and no done pulse.
REQ-040 start with opcode=ADDI -> illegal pulse next cycle, busy=0, HI/LO unchanged; MFLO then returns the prior lo.
REQ-041 MULDIV_DIV_EN undefined, DIV a=9, b=3 -> illegal pulse, no done, hi/lo unchanged.
